mem_stage_ctrl: RTL and testbench

- Consumer end of the EX/MEM pipeline register; forms the MEM stage of the 5-stage MIPS pipeline.
- Resolves branch and jump redirection from the EX/MEM flags.
- Runs load/store accesses on a req/ack data-memory port, stalling the pipeline while an access is outstanding.
- Aligns and extends load data, then registers the MEM/WB writeback fields.

---
 rtl/mem_stage_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 5-stage pipeline: branch/jump redirect, req/ack data-memory
// access with stall and timeout, load alignment and the MEM/WB register.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] PC_Branch_in,
  input  logic [31:0] PC_Jump_in,
  input  logic [31:0] ALUShift_in,
  input  logic [31:0] StoreData_in,
  input  logic        Jump_in,
  input  logic        Less_in,
  input  logic        Zero_in,
  input  logic        Overflow_in,
  input  logic [2:0]  Condition_in,
  input  logic [1:0]  LoadType_in,
  input  logic [1:0]  LoadByte_in,
  input  logic        RegWr_in,
  input  logic        MemWr_in,
  input  logic        MemtoReg_in,
  input  logic [4:0]  Rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        Stall,
  output logic        PC_Sel,
  output logic [31:0] PC_Target,
  output logic        Flush,
  output logic        Bus_Err,
  output logic [31:0] WbData,
  output logic [4:0]  Rd_wb,
  output logic        RegWr_wb
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_aborted, w_aborted_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic              w_bus_err_nxt;
  logic              w_memop, w_stall, w_req, w_cond;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load, w_wdata;
  logic [3:0]        w_be;

  assign w_memop = MemWr_in | MemtoReg_in;

  // State register; all pipeline state moves on the falling edge
  always_ff @(negedge clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_aborted <= 1'b0;
      r_rdata   <= '0;
      Bus_Err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_aborted <= w_aborted_nxt;
      r_rdata   <= w_rdata_nxt;
      Bus_Err   <= w_bus_err_nxt;
    end
  end

  // Access sequencing; an ack in the timeout cycle takes priority over abort
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_aborted_nxt = r_aborted;
    w_rdata_nxt   = r_rdata;
    w_bus_err_nxt = 1'b0;
    w_stall       = 1'b0;
    w_req         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          w_stall       = 1'b1;
          w_aborted_nxt = 1'b0;
          w_state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        w_req     = 1'b1;
        w_stall   = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (dmem_ack) begin
          w_rdata_nxt   = dmem_rdata;
          w_aborted_nxt = 1'b0;
          w_state_nxt   = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_bus_err_nxt = 1'b1;
          w_aborted_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store lane replication and little-endian byte enables
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = StoreData_in;
    case (LoadType_in)
      2'b01, 2'b10: begin
        w_be    = 4'b0001 << LoadByte_in;
        w_wdata = {4{StoreData_in[7:0]}};
      end
      2'b11: begin
        w_be    = LoadByte_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{StoreData_in[15:0]}};
      end
      default: ;
    endcase
  end

  assign Stall      = w_stall;
  assign dmem_req   = w_req;
  assign dmem_we    = MemWr_in;
  assign dmem_addr  = w_req ? {ALUShift_in[31:2], 2'b00} : 32'd0;
  assign dmem_wdata = w_req ? w_wdata : 32'd0;
  assign dmem_be    = w_req ? w_be : 4'd0;

  // Load lane select and extension from the captured read data
  always_comb begin
    w_byte = r_rdata[{LoadByte_in, 3'b000} +: 8];
    w_half = LoadByte_in[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (LoadType_in)
      2'b01:   w_load = {{24{w_byte[7]}}, w_byte};
      2'b10:   w_load = {24'd0, w_byte};
      2'b11:   w_load = {{16{w_half[15]}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    case (Condition_in)
      3'd1:    w_cond = Zero_in;
      3'd2:    w_cond = !Zero_in;
      3'd3:    w_cond = Less_in | Zero_in;
      3'd4:    w_cond = !Less_in & !Zero_in;
      3'd5:    w_cond = Less_in;
      3'd6:    w_cond = !Less_in;
      default: w_cond = 1'b0;
    endcase
  end

  assign PC_Sel    = !w_stall & (Jump_in | w_cond);
  assign Flush     = PC_Sel;
  assign PC_Target = w_stall ? 32'd0 : (Jump_in ? PC_Jump_in : PC_Branch_in);

  // MEM/WB register; a stalled cycle becomes a bubble
  always_ff @(negedge clk) begin
    if (Reset || w_stall) begin
      WbData   <= '0;
      Rd_wb    <= '0;
      RegWr_wb <= 1'b0;
    end else begin
      WbData   <= MemtoReg_in ? w_load : ALUShift_in;
      Rd_wb    <= Rd_in;
      RegWr_wb <= RegWr_in & !Overflow_in & !((r_state == S_DONE) & r_aborted);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: redirect, loads, stores, timeout and reset.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] PC_Branch_in, PC_Jump_in, ALUShift_in, StoreData_in;
  logic        Jump_in, Less_in, Zero_in, Overflow_in;
  logic [2:0]  Condition_in;
  logic [1:0]  LoadType_in, LoadByte_in;
  logic        RegWr_in, MemWr_in, MemtoReg_in;
  logic [4:0]  Rd_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        Stall, PC_Sel, Flush, Bus_Err, RegWr_wb;
  logic [31:0] PC_Target, WbData;
  logic [4:0]  Rd_wb;

  int errors = 0;
  int checks = 0;
  int waits;

  mem_stage_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .Reset(Reset),
    .PC_Branch_in(PC_Branch_in), .PC_Jump_in(PC_Jump_in),
    .ALUShift_in(ALUShift_in), .StoreData_in(StoreData_in),
    .Jump_in(Jump_in), .Less_in(Less_in), .Zero_in(Zero_in), .Overflow_in(Overflow_in),
    .Condition_in(Condition_in), .LoadType_in(LoadType_in), .LoadByte_in(LoadByte_in),
    .RegWr_in(RegWr_in), .MemWr_in(MemWr_in), .MemtoReg_in(MemtoReg_in), .Rd_in(Rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .Stall(Stall), .PC_Sel(PC_Sel), .PC_Target(PC_Target),
    .Flush(Flush), .Bus_Err(Bus_Err), .WbData(WbData), .Rd_wb(Rd_wb), .RegWr_wb(RegWr_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the active (falling) edge and let outputs settle
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    Jump_in = 0; Less_in = 0; Zero_in = 0; Overflow_in = 0; Condition_in = 0;
    RegWr_in = 0; MemWr_in = 0; MemtoReg_in = 0; Rd_in = 0;
    LoadType_in = 0; LoadByte_in = 0; ALUShift_in = 0; StoreData_in = 0;
    PC_Branch_in = 0; PC_Jump_in = 0;
  endtask

  // Byte load at 0x1003 with ack in the second WAIT cycle
  task automatic byte_load(input logic [1:0] ltype, input logic [31:0] exp, input string tag);
    nop();
    MemtoReg_in = 1; RegWr_in = 1; LoadType_in = ltype;
    ALUShift_in = 32'h0000_1003; LoadByte_in = 2'd3; Rd_in = 5'd5;
    #1;
    check({tag, "_stall_idle"}, Stall, 1);
    check({tag, "_req_idle"}, dmem_req, 0);
    step();
    check({tag, "_stall_w1"}, Stall, 1);
    check({tag, "_req_w1"}, dmem_req, 1);
    check({tag, "_addr"}, dmem_addr, 32'h0000_1000);
    check({tag, "_we"}, dmem_we, 0);
    step();
    dmem_ack = 1; dmem_rdata = 32'h8011_2233;
    #1;
    check({tag, "_stall_w2"}, Stall, 1);
    step();
    dmem_ack = 0; dmem_rdata = 0;
    #1;
    check({tag, "_stall_done"}, Stall, 0);
    check({tag, "_req_done"}, dmem_req, 0);
    step();
    check({tag, "_wbdata"}, WbData, exp);
    check({tag, "_regwr"}, RegWr_wb, 1);
    check({tag, "_rd"}, Rd_wb, 5);
    nop();
  endtask

  initial begin
    nop();
    Reset = 1; dmem_ack = 0; dmem_rdata = 0;
    step(); step();
    check("rst_wbdata", WbData, 0);
    check("rst_rd", Rd_wb, 0);
    check("rst_regwr", RegWr_wb, 0);
    check("rst_buserr", Bus_Err, 0);
    check("rst_req", dmem_req, 0);
    Reset = 0;
    step();

    // Jump redirect
    Jump_in = 1; PC_Jump_in = 32'h0040_0020; PC_Branch_in = 32'h0000_0444;
    #1;
    check("jmp_sel", PC_Sel, 1);
    check("jmp_target", PC_Target, 32'h0040_0020);
    check("jmp_flush", Flush, 1);
    check("jmp_stall", Stall, 0);
    nop();

    // bgtz taken, then not taken with Zero
    Condition_in = 3'd4; PC_Branch_in = 32'h0000_0100;
    #1;
    check("bgtz_sel", PC_Sel, 1);
    check("bgtz_target", PC_Target, 32'h0000_0100);
    Zero_in = 1;
    #1;
    check("bgtz_zero_sel", PC_Sel, 0);
    Condition_in = 3'd3;
    #1;
    check("blez_sel", PC_Sel, 1);
    Condition_in = 3'd7;
    #1;
    check("rsvd_sel", PC_Sel, 0);
    nop();
    step();

    byte_load(2'b01, 32'hFFFF_FF80, "lb");
    byte_load(2'b10, 32'h0000_0080, "lbu");

    // sh at 0x2002
    MemWr_in = 1; LoadType_in = 2'b11; LoadByte_in = 2'd2;
    ALUShift_in = 32'h0000_2002; StoreData_in = 32'hAAAA_1234; Rd_in = 5'd3;
    #1;
    check("sh_stall_idle", Stall, 1);
    step();
    check("sh_we", dmem_we, 1);
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    check("sh_addr", dmem_addr, 32'h0000_2000);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    #1;
    check("sh_stall_done", Stall, 0);
    step();
    check("sh_regwr", RegWr_wb, 0);
    nop();

    // lw that never gets an ack: 16 WAIT cycles then Bus_Err
    MemtoReg_in = 1; RegWr_in = 1; LoadType_in = 2'b00;
    ALUShift_in = 32'h0000_3000; Rd_in = 5'd7;
    step();
    waits = 0;
    for (int i = 0; i < 40 && dmem_req; i++) begin
      waits++;
      if (Bus_Err) check("to_early_buserr", Bus_Err, 0);
      step();
    end
    check("to_wait_cycles", waits, 16);
    check("to_buserr", Bus_Err, 1);
    check("to_stall_done", Stall, 0);
    step();
    check("to_regwr", RegWr_wb, 0);
    check("to_buserr_pulse", Bus_Err, 0);
    nop();
    #1;
    check("to_idle_req", dmem_req, 0);
    check("to_idle_stall", Stall, 0);

    // lw acked on exactly the 16th WAIT cycle
    MemtoReg_in = 1; RegWr_in = 1; LoadType_in = 2'b00;
    ALUShift_in = 32'h0000_3004; Rd_in = 5'd8;
    step();
    for (int n = 1; n <= 16; n++) begin
      if (n == 16) begin
        dmem_ack = 1; dmem_rdata = 32'h1234_5678;
      end
      if (n < 16) step();
    end
    step();
    dmem_ack = 0; dmem_rdata = 0;
    #1;
    check("ack16_buserr", Bus_Err, 0);
    check("ack16_req", dmem_req, 0);
    step();
    check("ack16_wbdata", WbData, 32'h1234_5678);
    check("ack16_regwr", RegWr_wb, 1);
    nop();

    // ALU op with and without overflow
    RegWr_in = 1; Overflow_in = 1; ALUShift_in = 32'h0000_0055; Rd_in = 5'd9;
    step();
    check("ovf_regwr", RegWr_wb, 0);
    check("ovf_wbdata", WbData, 32'h0000_0055);
    check("ovf_rd", Rd_wb, 9);
    Overflow_in = 0;
    step();
    check("add_regwr", RegWr_wb, 1);
    nop();

    // Reset while waiting; redirect suppressed while stalled
    MemtoReg_in = 1; RegWr_in = 1; ALUShift_in = 32'h0000_4000; Rd_in = 5'd4;
    step();
    Jump_in = 1; PC_Jump_in = 32'h0000_0800;
    #1;
    check("rstw_req", dmem_req, 1);
    check("stall_pcsel", PC_Sel, 0);
    check("stall_flush", Flush, 0);
    Reset = 1;
    step();
    nop();
    #1;
    check("rstw_req_drop", dmem_req, 0);
    check("rstw_wbdata", WbData, 0);
    check("rstw_rd", Rd_wb, 0);
    check("rstw_regwr", RegWr_wb, 0);
    check("rstw_buserr", Bus_Err, 0);
    Reset = 0;

    // Late ack in IDLE is ignored
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 0;
    #1;
    check("late_ack_req", dmem_req, 0);
    check("late_ack_stall", Stall, 0);
    check("late_ack_buserr", Bus_Err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
